// File: rtl/hwag_ign_channel.sv
// Single ignition-coil channel: charges the coil from (spark - delta) to spark on the crank angle.
// Optional dwell-time limit is built when HWAG_IGN_DWELL_LIMIT_EN is defined.
module hwag_ign_channel #(
    parameter int W       = 24,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [W-1:0]       acnt,
    input  logic [W-1:0]       acnt_top,
    input  logic [W-1:0]       ign_ang,
    input  logic [W-1:0]       dlt_ang,
    input  logic               upd,
    input  logic [DWELL_W-1:0] dwell_max,
    output logic               coil,
    output logic               spark_if,
    output logic               dwell_ovf_if
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CHARGE = 2'd2
    } state_t;

    state_t         state_q, state_d;

    logic [W-1:0]   inp_spk_q, inp_dlt_q;
    logic [W-1:0]   pipe_spk_q, pipe_chrg_q;
    logic           pipe_zero_q;
    logic [W-1:0]   act_spk_q, act_chrg_q;
    logic           act_zero_q;

    logic [W-1:0]   dlt_c;
    logic [W:0]     chrg_wide;

    logic           coil_q, spark_q, ovf_q;
    logic           coil_d, spark_d, ovf_d;
    logic           chrg_match, spk_match, dwell_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            inp_spk_q <= '0;
            inp_dlt_q <= '0;
        end else if (upd) begin
            inp_spk_q <= ign_ang;
            inp_dlt_q <= dlt_ang;
        end
    end

    // Charge angle wraps backwards through acnt_top when delta exceeds the spark angle.
    assign dlt_c     = (inp_dlt_q > acnt_top) ? acnt_top : inp_dlt_q;
    assign chrg_wide = (inp_spk_q >= dlt_c)
                     ? ({1'b0, inp_spk_q} - {1'b0, dlt_c})
                     : ({1'b0, inp_spk_q} + {1'b0, acnt_top} + (W+1)'(1) - {1'b0, dlt_c});

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_spk_q  <= '0;
            pipe_chrg_q <= '0;
            pipe_zero_q <= 1'b1;
        end else begin
            pipe_spk_q  <= inp_spk_q;
            pipe_chrg_q <= chrg_wide[W-1:0];
            pipe_zero_q <= (dlt_c == '0);
        end
    end

    // Active angles are frozen while charging so a running dwell is never retargeted.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_spk_q  <= '0;
            act_chrg_q <= '0;
            act_zero_q <= 1'b1;
        end else if (state_q != ST_CHARGE) begin
            act_spk_q  <= pipe_spk_q;
            act_chrg_q <= pipe_chrg_q;
            act_zero_q <= pipe_zero_q;
        end
    end

    assign chrg_match = !act_zero_q && (acnt == act_chrg_q);
    assign spk_match  = (acnt == act_spk_q);

`ifdef HWAG_IGN_DWELL_LIMIT_EN
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;

    assign dwell_inc    = dwell_q + 1'b1;
    // Compare the incremented count so the coil is high for exactly dwell_max clocks.
    assign dwell_expire = (dwell_max != '0) && (dwell_inc == dwell_max);

    always_comb begin
        dwell_d = dwell_q;
        if (state_q != ST_CHARGE && state_d == ST_CHARGE) begin
            dwell_d = '0;
        end else if (state_q == ST_CHARGE) begin
            dwell_d = dwell_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`else
    logic unused_dwell_max;

    assign unused_dwell_max = ^dwell_max;
    assign dwell_expire     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            coil_q  <= 1'b0;
            spark_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            coil_q  <= coil_d;
            spark_q <= spark_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_WAIT;
                ST_WAIT:   if (chrg_match) state_d = ST_CHARGE;
                ST_CHARGE: if (spk_match || dwell_expire) state_d = ST_WAIT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Spark match outranks the dwell limit; disable suppresses both pulses.
    always_comb begin
        coil_d  = (state_d == ST_CHARGE);
        spark_d = ena && (state_q == ST_CHARGE) && spk_match;
        ovf_d   = ena && (state_q == ST_CHARGE) && !spk_match && dwell_expire;
    end

    assign coil         = coil_q;
    assign spark_if     = spark_q;
    assign dwell_ovf_if = ovf_q;

endmodule

// File: tb/tb_hwag_ign_channel.sv
// Self-checking bench for hwag_ign_channel: angle-level reference model plus directed scenarios.
// Dwell-limit scenario runs only when HWAG_IGN_DWELL_LIMIT_EN is defined.
module tb_hwag_ign_channel;

    localparam int W       = 24;
    localparam int DWELL_W = 24;
`ifdef HWAG_IGN_DWELL_LIMIT_EN
    localparam bit DWELL_ON = 1'b1;
`else
    localparam bit DWELL_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ena = 1'b0;
    logic [W-1:0]       acnt = '0;
    logic [W-1:0]       acnt_top = 24'd999;
    logic [W-1:0]       ign_ang = '0;
    logic [W-1:0]       dlt_ang = '0;
    logic               upd = 1'b0;
    logic [DWELL_W-1:0] dwell_max = '0;
    logic               coil, spark_if, dwell_ovf_if;

    hwag_ign_channel #(.W(W), .DWELL_W(DWELL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .acnt         (acnt),
        .acnt_top     (acnt_top),
        .ign_ang      (ign_ang),
        .dlt_ang      (dlt_ang),
        .upd          (upd),
        .dwell_max    (dwell_max),
        .coil         (coil),
        .spark_if     (spark_if),
        .dwell_ovf_if (dwell_ovf_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Reference model: requested angles become active two clocks after upd, but only
    // while not charging; charge angle is derived with modular arithmetic.
    typedef struct {
        int ready;
        int spk;
        int dlt;
    } req_t;

    req_t req_q[$];
    int   m_spk = 0, m_dlt = 0, m_start = 0;
    bit   m_enabled = 0, m_charging = 0;
    bit   m_coil = 0, m_spark = 0, m_ovf = 0;

    // Monitor state: acnt values at which coil rose/fell, pulse counts.
    int   rise_q[$];
    int   fall_q[$];
    int   rise_cyc = 0, fall_cyc = 0;
    int   n_spark = 0, n_spark_fall = 0, n_ovf = 0;

    initial begin
        int  cyc;
        int  prev_acnt;
        bit  prev_coil;
        int  top, dc, chrg;
        bit  was;
        cyc       = 0;
        prev_acnt = 0;
        prev_coil = 0;
        forever begin
            @(negedge clk);
            check("coil",         int'(coil),         int'(m_coil));
            check("spark_if",     int'(spark_if),     int'(m_spark));
            check("dwell_ovf_if", int'(dwell_ovf_if), int'(m_ovf));

            if (coil && !prev_coil) begin
                rise_q.push_back(prev_acnt);
                rise_cyc = cyc;
            end
            if (!coil && prev_coil) begin
                fall_q.push_back(prev_acnt);
                fall_cyc = cyc;
            end
            if (spark_if) n_spark++;
            if (spark_if && prev_coil && !coil) n_spark_fall++;
            if (dwell_ovf_if) n_ovf++;
            prev_coil = coil;
            prev_acnt = int'(acnt);

            if (rst) begin
                m_enabled  = 0;
                m_charging = 0;
                m_spark    = 0;
                m_ovf      = 0;
                m_spk      = 0;
                m_dlt      = 0;
                req_q.delete();
            end else begin
                top  = int'(acnt_top);
                dc   = (m_dlt > top) ? top : m_dlt;
                chrg = (m_spk + top + 1 - dc) % (top + 1);
                was  = m_charging;
                m_spark = 0;
                m_ovf   = 0;
                if (!ena) begin
                    m_enabled  = 0;
                    m_charging = 0;
                end else if (!m_enabled) begin
                    m_enabled = 1;
                end else if (!m_charging) begin
                    if (dc != 0 && int'(acnt) == chrg) begin
                        m_charging = 1;
                        m_start    = cyc;
                    end
                end else if (int'(acnt) == m_spk) begin
                    m_charging = 0;
                    m_spark    = 1;
                end else if (DWELL_ON && dwell_max != '0 && (cyc - m_start) == int'(dwell_max)) begin
                    m_charging = 0;
                    m_ovf      = 1;
                end
                if (!was) begin
                    while (req_q.size() > 0 && req_q[0].ready <= cyc) begin
                        m_spk = req_q[0].spk;
                        m_dlt = req_q[0].dlt;
                        void'(req_q.pop_front());
                    end
                end
                if (upd) req_q.push_back('{cyc + 2, int'(ign_ang), int'(dlt_ang)});
            end
            m_coil = m_charging;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_upd(input int spk, input int dlt);
        ign_ang = W'(spk);
        dlt_ang = W'(dlt);
        upd     = 1'b1;
        tick();
        upd     = 1'b0;
    endtask

    task automatic adv(input int steps, input int per);
        for (int i = 0; i < steps; i++) begin
            acnt = (acnt == acnt_top) ? '0 : acnt + 1'b1;
            repeat (per) tick();
        end
    endtask

    task automatic clear_log();
        rise_q.delete();
        fall_q.delete();
    endtask

    initial begin
        int sp0, sf0, ov0;

        repeat (3) tick();
        check("reset_coil",  int'(coil),         0);
        check("reset_spark", int'(spark_if),     0);
        check("reset_ovf",   int'(dwell_ovf_if), 0);
        rst = 1'b0;
        ena = 1'b1;

        // Basic charge and spark
        clear_log();
        sp0 = n_spark; sf0 = n_spark_fall;
        do_upd(500, 100);
        adv(1000, 2);
        check("basic_rise_acnt",  q_at(rise_q, 0), 400);
        check("basic_fall_acnt",  q_at(fall_q, 0), 500);
        check("basic_spark_cnt",  n_spark - sp0, 1);
        check("basic_spark_fall", n_spark_fall - sf0, 1);

        // Mid-charge update: old spark still fires, new angles used afterwards
        clear_log();
        sp0 = n_spark;
        adv(450, 2);
        check("mid_coil_on", int'(coil), 1);
        do_upd(700, 100);
        adv(550, 2);
        check("mid_rise0",     q_at(rise_q, 0), 400);
        check("mid_fall0",     q_at(fall_q, 0), 500);
        check("mid_rise1",     q_at(rise_q, 1), 600);
        check("mid_fall1",     q_at(fall_q, 1), 700);
        check("mid_spark_cnt", n_spark - sp0, 2);

        // Wrap: charge across acnt_top -> 0
        clear_log();
        sp0 = n_spark;
        do_upd(50, 100);
        adv(1060, 2);
        check("wrap_rise",      q_at(rise_q, 0), 950);
        check("wrap_fall",      q_at(fall_q, 0), 50);
        check("wrap_spark_cnt", n_spark - sp0, 1);

        // Disable in CHARGE
        clear_log();
        sp0 = n_spark;
        do_upd(500, 100);
        adv(390, 2);
        check("dis_coil_on", int'(coil), 1);
        ena = 1'b0;
        tick();
        check("dis_coil_off", int'(coil), 0);
        adv(150, 2);
        ena = 1'b1;
        check("dis_fall",      q_at(fall_q, 0), 450);
        check("dis_spark_cnt", n_spark - sp0, 0);

        // Zero delta never charges
        clear_log();
        sp0 = n_spark;
        do_upd(500, 0);
        adv(1000, 2);
        check("zero_rises",     rise_q.size(), 0);
        check("zero_spark_cnt", n_spark - sp0, 0);

        // Clamp: delta 5000 limited to acnt_top
        clear_log();
        sp0 = n_spark;
        do_upd(500, 5000);
        adv(1900, 2);
        check("clamp_rise",      q_at(rise_q, 0), 501);
        check("clamp_fall",      q_at(fall_q, 0), 500);
        check("clamp_spark_cnt", n_spark - sp0, 1);
        adv(20, 2);

`ifdef HWAG_IGN_DWELL_LIMIT_EN
        // Dwell limit: slow acnt so the clock limit expires before spark
        clear_log();
        sp0 = n_spark; ov0 = n_ovf;
        dwell_max = DWELL_W'(20);
        do_upd(500, 100);
        adv(870, 2);
        adv(30, 10);
        check("dwell_rise",      q_at(rise_q, 0), 400);
        check("dwell_len",       fall_cyc - rise_cyc, 20);
        check("dwell_ovf_cnt",   n_ovf - ov0, 1);
        adv(100, 2);
        check("dwell_spark_cnt", n_spark - sp0, 0);
        dwell_max = '0;
`else
        ov0 = 0;
        check("no_dwell_ovf", n_ovf - ov0, 0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hwag_ign_channel.md
# hwag_ign_channel

Single ignition-coil output channel, directly downstream of the HWAG angle generator. It takes the running crank angle (ACNT2), the spark angle (HWAIGNANG) and the charge-delta angle produced by the HWAG divider. It drives a coil output that asserts at `spark − delta` and releases at `spark`, with the spark angle modulo the angle-counter period. It also raises a one-cycle spark interrupt pulse and, optionally, a dwell-overrun interrupt pulse.

## Interface
- `W`, 24, width of angle values.
- `DWELL_W`, 24, width of the dwell-limit clock counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `ena`  in  1  channel enable (driven from hwag_start); low forces IDLE.
- `acnt`  in  W  current angle (acnt2_out); steps by at most 1 per clock and wraps `acnt_top` → 0.
- `acnt_top`  in  W  last angle value of the cycle (HWAMAXACR[23:0]).
- `ign_ang`  in  W  spark angle, range 0..acnt_top.
- `dlt_ang`  in  W  charge-delta angle (delta_ign_angle).
- `upd`  in  1  one-clock strobe (vr_edge_0): sample `ign_ang`/`dlt_ang`.
- `dwell_max`  in  DWELL_W  maximum charge time in clocks (used only with the macro).
- `coil`  out  1  coil drive, 1 = charging.
- `spark_if`  out  1  one-clock pulse at normal spark.
- `dwell_ovf_if`  out  1  one-clock pulse at forced dwell termination.

## Operation
- **Input registers.** `inp_spk` and `inp_dlt` load from `ign_ang`/`dlt_ang` on `upd`.
- **Clamp.** `dlt_c = min(inp_dlt, acnt_top)`.
- **Charge-angle pipeline register.** Computed 1 clock after `inp_*` change:
  - `chrg = inp_spk − dlt_c` when `inp_spk ≥ dlt_c`.
  - Otherwise `chrg = inp_spk + acnt_top + 1 − dlt_c`.
  - The computation uses W+1 bits internally; the result fits in W.
- **Active registers.** `act_spk`/`act_chrg`/`act_zero` (`act_zero` = `dlt_c == 0`) copy from the pipeline in any state except CHARGE. In CHARGE they are frozen; the pending copy is taken on the first clock after leaving CHARGE.
- **States:**
  - IDLE: `coil` = 0. Go to WAIT when `ena` = 1.
  - WAIT: `coil` = 0. Go to CHARGE when `acnt == act_chrg` and `act_zero` = 0.
  - CHARGE: `coil` = 1.
    - If `acnt == act_spk`: go to WAIT and pulse `spark_if`.
    - Dwell overrun (macro only): go to WAIT and pulse `dwell_ovf_if`.
- **Priority:** `ena` = 0 first (any state → IDLE, no pulses), then the spark match, then the dwell overrun.
- **Delta 0.** With `dlt_c` = 0 the channel never charges and never sparks.
- **Equality-only compares.** A jump of `acnt` past an angle (e.g. ACNT2 reload) misses that event. WAIT then waits for the next revolution. CHARGE stays charging until the next revolution's spark match, bounded by the dwell limit when compiled in.

## Timing
- **Reset values:** `coil` = 0, `spark_if` = 0, `dwell_ovf_if` = 0, state IDLE, all angle registers 0, dwell counter 0.
- **Outputs are registered.** `coil` changes on the clock after the matching `acnt` value is presented.
- **Pulses.** `spark_if`/`dwell_ovf_if` are high on the same clock that `coil` falls.
- **`upd` to usable angles:** 2 clocks (input register, then pipeline register). The active copy follows on the next clock outside CHARGE.
- **Update vs. compare on the same clock.** The compare uses the old active values.
- **Disable.** `ena` falling in CHARGE drops `coil` on the next clock, with no pulse.
- **Reset during CHARGE.** `rst` in CHARGE gives `coil` = 0 on the next clock.

## Configuration
- Macro: `HWAG_IGN_DWELL_LIMIT_EN`.
- **Defined:**
  - A DWELL_W counter clears on CHARGE entry and increments each clock in CHARGE.
  - When the counter equals `dwell_max`, the channel forces an exit to WAIT and pulses `dwell_ovf_if`.
  - `dwell_max` = 0 disables the limit.
- **Undefined:** no counter is built, `dwell_max` is ignored, and `dwell_ovf_if` is constant 0.

## Test plan
- **Basic charge and spark.** Stimulus: `acnt_top`=999, `upd` with `ign_ang`=500, `dlt_ang`=100, `ena`=1, `acnt` stepping 0..999 one step per 2 clocks.
  - `coil` rises the clock after `acnt`=400.
  - `coil` falls the clock after `acnt`=500.
  - `spark_if` is high exactly 1 clock, coincident with the fall.
- **Wrap.** Stimulus: `ign_ang`=50, `dlt_ang`=100, `acnt_top`=999. Response: `coil` rises after `acnt`=950 and falls after wrap at `acnt`=50, with one `spark_if`.
- **Mid-charge update.** Stimulus: during CHARGE of the first scenario, `upd` with `ign_ang`=700, `dlt_ang`=100.
  - Spark still occurs at 500.
  - The next cycle charges at 600 and sparks at 700.
- **Disable and zero delta.**
  - `ena`→0 at `acnt`=450 in CHARGE: `coil`=0 next clock, no `spark_if`.
  - `dlt_ang`=0: `coil` stays 0 for a full revolution.
- **Clamp.** Stimulus: `dlt_ang`=5000, `ign_ang`=500, `acnt_top`=999. Response: `dlt_c`=999, so `chrg`=501; `coil` rises after `acnt`=501 and sparks after the next `acnt`=500.
- **Dwell limit (macro defined).** Stimulus: `dwell_max`=20, `acnt` stepping every 10 clocks, `dlt_ang`=100. Response: `coil` falls 20 clocks after rising, with one `dwell_ovf_if` and no `spark_if`.
